// File: rtl/line_ddr_writer.sv
`default_nettype none
// ============================================================================
// Module   : line_ddr_writer
// Purpose  : Consumer side of the camera line buffer. A start request triggers
//            the line buffer. Each line is then drained in chunks of
//            8*BURST_LEN RGB565 pixels. Eight pixels are packed into each
//            128-bit staging word, and every chunk is written to DDR as one
//            AXI4 INCR burst.
// Ports    : clk_i/rstn_i        clock, asynchronous active-low reset
//            start_i             frame request (accepted only when idle)
//            busy_o/done_o/err_o frame status (err sticky until next start)
//            lb_*                line-buffer trigger, ready, read strobe, data
//            aw*/w*/b*           AXI4 write address, data and response channels
// Revision : 1.0 - initial release
// ============================================================================
module line_ddr_writer #(
    parameter int                H_ACT       = 1280,
    parameter int                V_ACT       = 720,
    parameter int                BURST_LEN   = 16,
    parameter int                ADDR_W      = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                LINE_STRIDE = 2560
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              lb_trig_o,
    input  logic              lb_aquire_i,
    output logic              lb_read_en_o,
    input  logic [15:0]       lb_data_i,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic [7:0]        awlen_o,
    output logic [2:0]        awsize_o,
    output logic [1:0]        awburst_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [127:0]      wdata_o,
    output logic [15:0]       wstrb_o,
    output logic              wvalid_o,
    output logic              wlast_o,
    input  logic              wready_i,
    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o
);

    localparam int PIX_PER_CHUNK = 8 * BURST_LEN;
    localparam int PIX_W         = $clog2(PIX_PER_CHUNK);
    localparam int WORD_W        = $clog2(BURST_LEN);
    localparam int CHUNKS        = H_ACT / PIX_PER_CHUNK;
    localparam int CHUNK_W       = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int ROW_W         = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam int CHUNK_BYTES   = BURST_LEN * 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TRIG = 3'd1,
        S_WAIT = 3'd2,
        S_FILL = 3'd3,
        S_AW   = 3'd4,
        S_W    = 3'd5,
        S_B    = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [PIX_W:0]       rd_cnt_q;   // reads issued in this chunk (0..PIX_PER_CHUNK)
    logic [PIX_W-1:0]     cap_cnt_q;  // pixel slot for the next capture
    logic                 cap_v_q;    // lb_data_i carries a requested pixel this cycle
    logic [WORD_W-1:0]    word_q;
    logic [CHUNK_W-1:0]   chunk_q;
    logic [ROW_W-1:0]     row_q;
    logic                 done_q;
    logic                 err_q;
    logic [7:0][15:0]     stage_q [BURST_LEN];

    logic                 w_rd_en;
    logic                 w_last_cap;
    logic                 w_last_word;
    logic                 w_last_chunk;
    logic                 w_last_row;
    logic [ADDR_W-1:0]    w_addr;

    // Read strobe runs until exactly one chunk of reads has been issued.
    assign w_rd_en      = (state_q == S_FILL) && !rd_cnt_q[PIX_W];
    assign w_last_cap   = cap_v_q && (cap_cnt_q == PIX_W'(PIX_PER_CHUNK - 1));
    assign w_last_word  = (word_q == WORD_W'(BURST_LEN - 1));
    assign w_last_chunk = (chunk_q == CHUNK_W'(CHUNKS - 1));
    assign w_last_row   = (row_q == ROW_W'(V_ACT - 1));
    assign w_addr       = BASE_ADDR
                        + ADDR_W'(row_q) * ADDR_W'(LINE_STRIDE)
                        + ADDR_W'(chunk_q) * ADDR_W'(CHUNK_BYTES);

    always_comb begin
        state_d = state_q;
        case (state_q)
            // A start landing in the done cycle is dropped on purpose.
            S_IDLE: if (start_i && !done_q)    state_d = S_TRIG;
            S_TRIG:                            state_d = S_WAIT;
            S_WAIT: if (lb_aquire_i)           state_d = S_FILL;
            S_FILL: if (w_last_cap)            state_d = S_AW;
            S_AW:   if (awready_i)             state_d = S_W;
            S_W:    if (wready_i && w_last_word) state_d = S_B;
            S_B:    if (bvalid_i)
                        state_d = (w_last_chunk && w_last_row) ? S_IDLE : S_WAIT;
            default:                           state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            cap_cnt_q <= '0;
            cap_v_q   <= 1'b0;
            word_q    <= '0;
            chunk_q   <= '0;
            row_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            cap_v_q <= w_rd_en;
            if (w_rd_en) rd_cnt_q  <= rd_cnt_q + 1'b1;
            if (cap_v_q) cap_cnt_q <= cap_cnt_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (state_d == S_TRIG) begin
                        err_q   <= 1'b0;
                        row_q   <= '0;
                        chunk_q <= '0;
                    end
                end
                S_WAIT: begin
                    rd_cnt_q  <= '0;
                    cap_cnt_q <= '0;
                    word_q    <= '0;
                end
                S_W: begin
                    if (wready_i) word_q <= w_last_word ? '0 : word_q + 1'b1;
                end
                S_B: begin
                    if (bvalid_i) begin
                        if (bresp_i != 2'b00) err_q <= 1'b1;
                        if (w_last_chunk) begin
                            chunk_q <= '0;
                            if (w_last_row) begin
                                row_q  <= '0;
                                done_q <= 1'b1;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            chunk_q <= chunk_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Staging buffer: pixel k of a word lands in bits [16k+15:16k].
    always_ff @(posedge clk_i) begin
        if (cap_v_q) stage_q[cap_cnt_q[PIX_W-1:3]][cap_cnt_q[2:0]] <= lb_data_i;
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign lb_trig_o    = (state_q == S_TRIG);
    assign lb_read_en_o = w_rd_en;
    assign awvalid_o    = (state_q == S_AW);
    assign awaddr_o     = (state_q == S_AW) ? w_addr : '0;
    assign awlen_o      = 8'(BURST_LEN - 1);
    assign awsize_o     = 3'd4;
    assign awburst_o    = 2'b01;
    assign wvalid_o     = (state_q == S_W);
    assign wlast_o      = (state_q == S_W) && w_last_word;
    assign wdata_o      = (state_q == S_W) ? stage_q[word_q] : '0;
    assign wstrb_o      = 16'hFFFF;
    assign bready_o     = (state_q == S_B);

endmodule
`default_nettype wire

// File: tb/tb_line_ddr_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_ddr_writer
// Purpose  : Directed self-checking bench for line_ddr_writer. Models the line
//            buffer read port and an AXI slave with optional stalls, and checks
//            burst addresses, packed data, wlast, channel hold and frame status.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_ddr_writer;

    logic         clk = 1'b0, rstn = 1'b0, start = 1'b0;
    logic         lb_aquire = 1'b1, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [15:0]  lb_data = '0;
    logic [1:0]   bresp = '0;
    logic         busy, done, err, lb_trig, lb_read_en, awvalid, wvalid, wlast, bready;
    logic [27:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic [127:0] wdata;
    logic [15:0]  wstrb;

    int n_checks = 0, n_errors = 0;
    int pix = 0, aw_cnt = 0, w_cnt = 0, beat = 0, b_cnt = 0, done_cnt = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, hold_left = 0, err_burst = -1;
    bit rd_pend = 0, aw_stall = 0, w_stall = 0, w_hold_last = 0;
    bit bp = 0, stall3 = 0, spam = 0, sod = 0, seen = 0;
    logic [27:0]  aw_hold_addr = '0;
    logic [127:0] w_hold_data = '0;

    line_ddr_writer #(
        .H_ACT(256), .V_ACT(4), .BURST_LEN(16), .ADDR_W(28),
        .BASE_ADDR(28'h100000), .LINE_STRIDE(2560)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .busy_o(busy), .done_o(done),
        .err_o(err), .lb_trig_o(lb_trig), .lb_aquire_i(lb_aquire),
        .lb_read_en_o(lb_read_en), .lb_data_i(lb_data), .awaddr_o(awaddr),
        .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst), .awvalid_o(awvalid),
        .awready_i(awready), .wdata_o(wdata), .wstrb_o(wstrb), .wvalid_o(wvalid),
        .wlast_o(wlast), .wready_i(wready), .bresp_i(bresp), .bvalid_i(bvalid),
        .bready_o(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Burst b of the frame: row b/2, chunk b%2; 0xA00 line stride, 0x100 per chunk.
    function automatic logic [27:0] exp_addr(input int b);
        return 28'h100000 + 28'((b / 2) * 2560 + (b % 2) * 256);
    endfunction

    // Pixels are numbered consecutively through the frame by the line-buffer model.
    function automatic logic [127:0] exp_word(input int b, input int bt);
        logic [127:0] w;
        int base;
        base = b * 128 + bt * 8;
        for (int k = 0; k < 8; k++) w[16*k +: 16] = 16'(base + k);
        return w;
    endfunction

    // Line-buffer read port, AXI slave and channel monitor, all on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                rd_pend = 0; aw_stall = 0; w_stall = 0;
                awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
                aw_wait = 0; w_wait = 0; b_wait = 0;
            end else begin
                if (rd_pend) begin
                    lb_data = 16'(pix);
                    pix++;
                end
                rd_pend = lb_read_en;
                if (hold_left > 0) begin
                    chk("rd_en_no_aquire", 160'(lb_read_en), 160'(0));
                    hold_left--;
                    if (hold_left == 0) lb_aquire = 1'b1;
                end
                if (aw_stall) chk("aw_hold", 160'({awvalid, awaddr}), 160'({1'b1, aw_hold_addr}));
                if (w_stall)  chk("w_hold", 160'({wvalid, wlast, wdata}),
                                  160'({1'b1, w_hold_last, w_hold_data}));
                // AW channel
                awready = 1'b0;
                if (awvalid) begin
                    if (aw_wait > 0) aw_wait--; else awready = 1'b1;
                end
                aw_stall = awvalid && !awready;
                aw_hold_addr = awaddr;
                if (awvalid && awready) begin
                    chk("awaddr", 160'(awaddr), 160'(exp_addr(aw_cnt)));
                    chk("aw_w_overlap", 160'(wvalid), 160'(0));
                    aw_cnt++;
                    aw_wait = bp ? int'($urandom_range(0, 20)) : 0;
                end
                // W channel
                wready = 1'b0;
                if (wvalid) begin
                    if (w_wait > 0) w_wait--; else wready = 1'b1;
                end
                w_stall = wvalid && !wready;
                w_hold_data = wdata;
                w_hold_last = wlast;
                if (wvalid && wready) begin
                    chk("wdata", 160'(wdata), 160'(exp_word(w_cnt, beat)));
                    chk("wlast", 160'(wlast), 160'(beat == 15));
                    beat++;
                    if (beat == 16) begin
                        beat = 0;
                        w_cnt++;
                    end
                    w_wait = bp ? int'($urandom_range(0, 20)) : 0;
                end
                // B channel
                bvalid = 1'b0;
                bresp  = 2'b00;
                if (bready) begin
                    if (b_wait > 0) b_wait--;
                    else begin
                        bvalid = 1'b1;
                        bresp  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
                    end
                end
                if (bvalid && bready) begin
                    chk("beats_per_burst", 160'(beat), 160'(0));
                    b_cnt++;
                    b_wait = bp ? int'($urandom_range(0, 20)) : 0;
                    if (stall3 && b_cnt == 3) begin
                        lb_aquire = 1'b0;
                        hold_left = 50;
                    end
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic run_frame(input bit exp_err);
        bit got;
        got = 0;
        @(negedge clk);
        pix = 0; aw_cnt = 0; w_cnt = 0; beat = 0; b_cnt = 0; done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("trig_state", 160'({busy, lb_trig, err}), 160'(3'b110));
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                got = 1;
                chk("err_at_done", 160'(err), 160'(exp_err));
                chk("busy_at_done", 160'(busy), 160'(0));
                if (sod) start = 1'b1;
                break;
            end
            if (spam && busy && (i % 150) == 60) start = 1'b1;
            if (spam && (i % 150) == 63) chk("busy_during_spam", 160'(busy), 160'(1));
        end
        chk("done_seen", 160'(got), 160'(1));
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("aw_count", 160'(aw_cnt), 160'(8));
        chk("w_bursts", 160'(w_cnt), 160'(8));
        chk("b_count", 160'(b_cnt), 160'(8));
        chk("done_once", 160'(done_cnt), 160'(1));
        chk("idle_after", 160'(busy), 160'(0));
        chk("err_hold", 160'(err), 160'(exp_err));
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ctl", 160'({busy, done, err, lb_trig, lb_read_en, awvalid, wvalid, wlast, bready}), 160'(0));
        chk("rst_data", 160'({awaddr, wdata}), 160'(0));
        @(negedge clk);
        rstn = 1'b1;
        chk("aw_consts", 160'({awlen, awsize, awburst, wstrb}), 160'({8'd15, 3'd4, 2'b01, 16'hFFFF}));

        // Reset in the middle of a fill, then a clean frame from row 0
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lb_read_en) begin
                seen = 1;
                break;
            end
        end
        chk("fill_reached", 160'(seen), 160'(1));
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_mid_ctl", 160'({busy, done, err, lb_trig, lb_read_en, awvalid, wvalid, wlast, bready}), 160'(0));
        chk("rst_mid_data", 160'({awaddr, wdata}), 160'(0));
        @(negedge clk);
        rstn = 1'b1;
        run_frame(1'b0);

        // Plain frame, everything ready
        run_frame(1'b0);

        // Line buffer not ready for 50 cycles before the fourth chunk
        stall3 = 1;
        run_frame(1'b0);
        stall3 = 0;

        // Random AXI backpressure
        bp = 1;
        run_frame(1'b0);
        bp = 0;

        // Error response on the fifth burst, then cleared by the next start
        err_burst = 4;
        run_frame(1'b1);
        err_burst = -1;
        run_frame(1'b0);

        // Start pulses while busy and in the done cycle are ignored
        spam = 1;
        sod  = 1;
        run_frame(1'b0);
        spam = 0;
        sod  = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
